// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - writeback requesters, issue, hazard query and write-port bundle
interface regfile_wb_scheduler_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;
  logic [31:0] busy;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd, rs1, rs2,
    input  a_ready, b_ready, hazard, RegWrite, rd, rd_write_data, busy
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd, rs1, rs2,
    output a_ready, b_ready, hazard, RegWrite, rd, rd_write_data, busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - two-requester writeback arbiter with busy scoreboard and hazard query
// REGFILE_WB_RR_EN selects round-robin arbitration; default is fixed priority to A.
module regfile_wb_scheduler (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave wb
);
  logic        a_win;
  logic        b_win;
  logic        xfer;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [31:0] busy_q;
  logic [31:0] busy_next;
  logic        haz1;
  logic        haz2;

`ifdef REGFILE_WB_RR_EN
  // prio_b=0 after reset so A takes the first contention; afterwards the loser gets priority.
  logic prio_b;

  always_comb begin
    a_win = wb.a_valid && !(wb.b_valid && prio_b);
    b_win = wb.b_valid && (!wb.a_valid || prio_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio_b <= 1'b0;
    else if (wb.a_valid && wb.b_valid)
      prio_b <= a_win;
  end
`else
  always_comb begin
    a_win = wb.a_valid;
    b_win = wb.b_valid && !wb.a_valid;
  end
`endif

  assign wb.a_ready = !rst && a_win;
  assign wb.b_ready = !rst && b_win;

  always_comb begin
    xfer     = wb.a_ready || wb.b_ready;
    sel_rd   = wb.a_ready ? wb.a_rd : wb.b_rd;
    sel_data = wb.a_ready ? wb.a_data : wb.b_data;
  end

  // x0 beats are consumed but leave the write port idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= 32'd0;
    end else if (xfer && sel_rd != 5'd0) begin
      we_q   <= 1'b1;
      rd_q   <= sel_rd;
      data_q <= sel_data;
    end else begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= 32'd0;
    end
  end

  // Set after clear so a same-edge reservation of the register being retired survives.
  always_comb begin
    busy_next = busy_q;
    if (we_q)
      busy_next[rd_q] = 1'b0;
    if (wb.iss_valid)
      busy_next[wb.iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= 32'd0;
    else
      busy_q <= busy_next;
  end

  always_comb begin
    haz1 = (wb.rs1 != 5'd0) && busy_q[wb.rs1] && !(we_q && rd_q == wb.rs1);
    haz2 = (wb.rs2 != 5'd0) && busy_q[wb.rs2] && !(we_q && rd_q == wb.rs2);
  end

  assign wb.hazard        = haz1 || haz2;
  assign wb.RegWrite      = we_q;
  assign wb.rd            = rd_q;
  assign wb.rd_write_data = data_q;
  assign wb.busy          = busy_q;
endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: a_valid input 1, a_rd input 5, a_data input 32, a_ready output 1; writeback requester A (ALU path).
REQ-004 SHALL have ports: b_valid input 1, b_rd input 5, b_data input 32, b_ready output 1; writeback requester B (load/CSR path).
REQ-005 SHALL have ports: iss_valid input 1, iss_rd input 5; instruction issue reserving a destination register.
REQ-006 SHALL have ports: rs1 input 5, rs2 input 5, hazard output 1; source operand readiness query.
REQ-007 SHALL have ports: RegWrite output 1, rd output 5, rd_write_data output 32; drives the register file's single write port.
REQ-008 SHALL have port: busy output 32; scoreboard, bit r set = write to xr pending.

Function
REQ-009 SHALL transfer a requester's beat in a cycle where its valid and ready are both 1; a requester holds valid, rd, data stable until transfer.
REQ-010 SHALL assert at most one of a_ready/b_ready per cycle; ready combinational from valids and arbitration state, never dependent on its own requester's ready.
REQ-011 SHALL assert ready for a lone valid requester in the same cycle (no idle bubble).
REQ-012 SHALL, when both valid, grant per REQ-028/REQ-029; loser's ready stays 0 and it retries next cycle.
REQ-013 SHALL register the granted beat onto RegWrite/rd/rd_write_data at the next rising edge: fixed 1-cycle latency, one write per cycle, full throughput.
REQ-014 SHALL drive RegWrite=1 for exactly one cycle per transferred beat with rd != 0.
REQ-015 SHALL accept a beat with rd == 0 normally but drive RegWrite=0 for it; busy unaffected.
REQ-016 SHALL drive RegWrite=0, rd=0, rd_write_data=0 in cycles with no transfer in the previous cycle.
REQ-017 SHALL set busy[iss_rd] at the edge where iss_valid=1 and iss_rd != 0; busy[0] is constantly 0.
REQ-018 SHALL clear busy[rd] at the edge ending a cycle in which RegWrite=1.
REQ-019 SHALL, when set and clear target the same register at the same edge, leave the bit set (newer reservation wins).
REQ-020 SHALL set or re-set an already-busy bit without error; no per-register counting.
REQ-021 SHALL compute hazard combinationally: 1 if (rs1 != 0, busy[rs1]=1, and not (RegWrite=1 and rd == rs1)) or the same for rs2; else 0.
REQ-022 SHALL exempt the register being written this cycle from hazard because the register file forwards write data to same-cycle reads.
REQ-023 SHALL NOT gate issue on hazard internally; stalling is the pipeline's decision.

Reset
REQ-024 SHALL, while rst=1, force busy=0, RegWrite=0, rd=0, rd_write_data=0, and arbitration pointer to A, independent of clk.
REQ-025 SHALL hold a_ready=0 and b_ready=0 while rst=1.
REQ-026 SHALL discard any beat registered for output when rst asserts mid-operation; no write issues after release.
REQ-027 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro REGFILE_WB_RR_EN defined, arbitrate round-robin: 1-bit pointer to last winner; on contention, the other requester wins; pointer updates only on a contended grant.
REQ-029 SHALL, without REGFILE_WB_RR_EN, arbitrate fixed priority: A always wins contention; B may starve.

Verification
REQ-030 SHALL cover: a_valid=1, a_rd=5, a_data=0xDEADBEEF alone -> a_ready=1 same cycle; next cycle RegWrite=1, rd=5, rd_write_data=0xDEADBEEF.
REQ-031 SHALL cover: A (rd=3) and B (rd=4) both valid 3 cycles -> fixed: A wins all three; with REGFILE_WB_RR_EN: A, B, A.
REQ-032 SHALL cover: iss_rd=7, then rs1=7 -> hazard=1; A writes rd=7 -> hazard=0 during RegWrite cycle, busy[7]=0 after.
REQ-033 SHALL cover: iss_valid with iss_rd=9 in the same cycle RegWrite=1, rd=9 -> busy[9]=1 after edge.
REQ-034 SHALL cover: beat with rd=0, data=0x1 -> ready=1, RegWrite stays 0; iss_rd=0 -> busy stays 0.
REQ-035 SHALL cover: rst pulsed asynchronously between transfer and output edge -> outputs 0 immediately, busy=0, no RegWrite after release.
